uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised UART receiver: baud tick generator, oversampling receive FSM and
//  FIFO in one block. Replaces the single-byte flag buffer with a DEPTH-entry FIFO.
//  Adds framing/overrun (optional parity) error reporting and break recovery.
//  Feeds the keyboard-to-monitor path; the consumer pops bytes with rd_en.
// PARAMETERS
//  CLK_DIV  326  clk cycles per oversample tick (50 MHz / (16*9600))
//  DBIT     8    data bits per frame, 5..9
//  OSR      16   oversample ticks per bit; even, >=8
//  FIFO_AW  3    FIFO address width; depth = 2**FIFO_AW
//  PAR_ODD  0    1 = odd parity, 0 = even (used only with UART_RX_PARITY_EN)
// PORTS
//  clk         in   1          system clock, rising edge
//  reset       in   1          synchronous, active-low
//  rx          in   1          serial input, async, idle high
//  rd_en       in   1          pop head of FIFO; ignored while empty
//  rd_data     out  DBIT       FIFO head (first-word fall-through)
//  empty       out  1          FIFO holds 0 entries
//  full        out  1          FIFO holds 2**FIFO_AW entries
//  count       out  FIFO_AW+1  current FIFO occupancy
//  busy        out  1          FSM not in IDLE
//  frame_err   out  1          1-cycle pulse: stop bit sampled low
//  overrun     out  1          1-cycle pulse: good byte dropped, FIFO full
//  parity_err  out  1          1-cycle pulse: parity mismatch (0 without macro)
// BEHAVIOUR
//  - reset=0 at clk edge: FSM IDLE, tick ctr 0, FIFO pointers 0, sync FFs 1;
//    rd_data=0, empty=1, full=0, count=0, busy=0, all error pulses 0.
//  - rx passes 2-FF synchroniser (reset to 1); all FSM decisions use rx_s.
//  - Tick ctr counts 0..CLK_DIV-1, free-running; s_tick=1 for the cycle at CLK_DIV-1.
//  - FSM (sample ctr s 0..OSR-1, bit ctr n 0..DBIT-1, shift reg LSB first):
//    IDLE: rx_s==0 -> START, s=0.
//    START: on s_tick; at s==OSR/2-1 sample: rx_s==1 -> IDLE (glitch, nothing
//      reported), else -> DATA, s=0, n=0.
//    DATA: at s==OSR-1 shift in rx_s, s=0; n==DBIT-1 -> PARITY (macro) or STOP.
//    PARITY: at s==OSR-1 compare rx_s with computed parity -> STOP.
//    STOP: at s==OSR-1 sample rx_s:
//      1 and no parity error -> push byte, IDLE.
//      1 with parity error -> parity_err pulse, drop, IDLE.
//      0 -> frame_err pulse, drop, BRK.
//    BRK: wait for rx_s==1, then IDLE (break/line-low never re-triggers START).
//  - Push occurs the cycle after the stop-sample tick; empty falls the next cycle.
//  - Push while full and no rd_en same cycle: overrun pulse, byte dropped,
//    FIFO contents and count unchanged. Push with rd_en while full: both
//    accepted, count unchanged, no overrun.
//  - rd_en while empty: no effect, count stays 0. Pointers wrap modulo depth.
//  - count = wr_ptr - rd_ptr, FIFO_AW+1 bits; full = count==2**FIFO_AW.
//  - Error pulses mutually exclusive per frame; never pushed to FIFO.
//  - Reset mid-frame aborts the frame, empties FIFO; no error pulse.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: PARITY state present, frame = start+DBIT+parity+
//    stop; even parity: XOR(data,par)==0; odd: ==1 (PAR_ODD).
//  Undefined: no PARITY state, DATA -> STOP, parity_err tied 0, PAR_ODD ignored.
// TESTING (sim with CLK_DIV=4, OSR=16, DBIT=8, FIFO_AW=2 unless noted)
//  1. Send 0x41 then 0xA5, no rd_en -> count=2, rd_data=0x41; rd_en -> rd_data=0xA5.
//  2. Send 5 bytes 0x01..0x05, no reads -> full=1 after 4th, overrun pulse on 5th,
//     FIFO pops 0x01..0x04 then empty=1.
//  3. rx low for 3*OSR*CLK_DIV/8 cycles (glitch < half bit) -> no push, busy returns 0.
//  4. Send 0x55 with stop bit 0, rx held low 20 bit times -> one frame_err, no push,
//     busy=1 until rx high; then 0x33 received correctly.
//  5. Macro on, PAR_ODD=0: 0x07 with parity 1 -> pushed; with parity 0 ->
//     parity_err pulse, count unchanged.
//  6. Assert reset=0 mid-DATA with count=2 -> next cycle empty=1, count=0, busy=0;
//     following frame 0x9C received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Bus bundle for uart_rx_fifo: serial line and pop request in, FIFO head, status and error pulses out.
interface uart_rx_fifo_if #(
  parameter int DBIT    = 8,
  parameter int FIFO_AW = 3
);
  logic               rx;
  logic               rd_en;
  logic [DBIT-1:0]    rd_data;
  logic               empty;
  logic               full;
  logic [FIFO_AW:0]   count;
  logic               busy;
  logic               frame_err;
  logic               overrun;
  logic               parity_err;

  modport slave (
    input  rx, rd_en,
    output rd_data, empty, full, count, busy, frame_err, overrun, parity_err
  );

  modport master (
    output rx, rd_en,
    input  rd_data, empty, full, count, busy, frame_err, overrun, parity_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with baud tick generator and first-word fall-through FIFO.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
  parameter int CLK_DIV = 326,
  parameter int DBIT    = 8,
  parameter int OSR     = 16,
  parameter int FIFO_AW = 3,
  parameter int PAR_ODD = 0
) (
  input logic           clk,
  input logic           reset,
  uart_rx_fifo_if.slave bus
);

  localparam int TW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW    = $clog2(OSR);
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int DEPTH = 1 << FIFO_AW;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif

  state_t            state_q;
  logic              rxMeta_q, rxSync_q;
  logic [TW-1:0]     tickCnt_q, tickCnt_d;
  logic              sTick;
  logic [SW-1:0]     sCnt_q;
  logic [NW-1:0]     nCnt_q;
  logic [DBIT-1:0]   shift_q;
  logic              pushReq_q;
  logic              frameErr_q;
  logic              parityErr_q;
`ifdef UART_RX_PARITY_EN
  logic              parErr_q;
`endif

  logic [DBIT-1:0]   mem_q [DEPTH];
  logic [FIFO_AW:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [FIFO_AW:0]  count;
  logic              emptyS, fullS, doPop, doPush, overrunD;
  logic              overrun_q;

  // Two-flop synchroniser; resets to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= bus.rx;
      rxSync_q <= rxMeta_q;
    end
  end

  assign sTick     = (tickCnt_q == TW'(CLK_DIV - 1));
  assign tickCnt_d = sTick ? '0 : tickCnt_q + TW'(1);

  always_ff @(posedge clk) begin
    if (!reset) tickCnt_q <= '0;
    else        tickCnt_q <= tickCnt_d;
  end

  // Receive FSM; error pulses and the push request are registered one-cycle strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      sCnt_q      <= '0;
      nCnt_q      <= '0;
      shift_q     <= '0;
      pushReq_q   <= 1'b0;
      frameErr_q  <= 1'b0;
      parityErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parErr_q    <= 1'b0;
`endif
    end else begin
      pushReq_q   <= 1'b0;
      frameErr_q  <= 1'b0;
      parityErr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rxSync_q) begin
            state_q <= START;
            sCnt_q  <= '0;
`ifdef UART_RX_PARITY_EN
            parErr_q <= 1'b0;
`endif
          end
        end
        START: begin
          if (sTick) begin
            if (sCnt_q == SW'(OSR/2 - 1)) begin
              if (rxSync_q) begin
                state_q <= IDLE;
              end else begin
                state_q <= DATA;
                sCnt_q  <= '0;
                nCnt_q  <= '0;
              end
            end else begin
              sCnt_q <= sCnt_q + SW'(1);
            end
          end
        end
        DATA: begin
          if (sTick) begin
            if (sCnt_q == SW'(OSR - 1)) begin
              sCnt_q  <= '0;
              shift_q <= {rxSync_q, shift_q[DBIT-1:1]};
              if (nCnt_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                nCnt_q <= nCnt_q + NW'(1);
              end
            end else begin
              sCnt_q <= sCnt_q + SW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sTick) begin
            if (sCnt_q == SW'(OSR - 1)) begin
              sCnt_q   <= '0;
              parErr_q <= ((^shift_q) ^ rxSync_q) != PAR_ODD[0];
              state_q  <= STOP;
            end else begin
              sCnt_q <= sCnt_q + SW'(1);
            end
          end
        end
`endif
        STOP: begin
          if (sTick) begin
            if (sCnt_q == SW'(OSR - 1)) begin
              sCnt_q <= '0;
              if (rxSync_q) begin
                state_q <= IDLE;
`ifdef UART_RX_PARITY_EN
                if (parErr_q) parityErr_q <= 1'b1;
                else          pushReq_q   <= 1'b1;
`else
                pushReq_q <= 1'b1;
`endif
              end else begin
                frameErr_q <= 1'b1;
                state_q    <= BRK;
              end
            end else begin
              sCnt_q <= sCnt_q + SW'(1);
            end
          end
        end
        BRK: begin
          if (rxSync_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count    = wrPtr_q - rdPtr_q;
  assign emptyS   = (count == '0);
  assign fullS    = (count == (FIFO_AW+1)'(DEPTH));
  assign doPop    = bus.rd_en & ~emptyS;
  assign doPush   = pushReq_q & (~fullS | doPop);
  assign overrunD = pushReq_q & fullS & ~bus.rd_en;
  assign wrPtr_d  = doPush ? wrPtr_q + (FIFO_AW+1)'(1) : wrPtr_q;
  assign rdPtr_d  = doPop  ? rdPtr_q + (FIFO_AW+1)'(1) : rdPtr_q;

  always_ff @(posedge clk) begin
    if (reset && doPush) mem_q[wrPtr_q[FIFO_AW-1:0]] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      overrun_q <= overrunD;
    end
  end

  assign bus.rd_data    = emptyS ? '0 : mem_q[rdPtr_q[FIFO_AW-1:0]];
  assign bus.empty      = emptyS;
  assign bus.full       = fullS;
  assign bus.count      = count;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_err  = frameErr_q;
  assign bus.overrun    = overrun_q;
  assign bus.parity_err = parityErr_q;

endmodule
